trajectory_sampler: RTL and testbench
=====================================

# trajectory_sampler

Downstream consumer of the projectile-parameter stage: takes the launch velocity components and gravity (all ×100 fixed-point, as produced upstream), integrates the flight in fixed time steps, and streams (x, y) position samples over a valid/ready handshake until touchdown or a sample limit. It feeds plotting/telemetry logic that needs the path, not just summary numbers.

## Interface
Parameters:
- DT_SHIFT, 4, time step = 2^-DT_SHIFT s (range 1..8)
- MAX_SAMPLES, 1024, hard cap on samples per flight including sample 0 (≥2)
- IDX_W, 10, width of sample index (≥ clog2(MAX_SAMPLES))

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  pulse; launch a flight (honoured only in IDLE)
- abort  input  1  synchronous abort, return to IDLE
- horizontalVelocity  input  16  vx, cm/s, unsigned
- verticalVelocity  input  16  vy, cm/s, unsigned (upward)
- customGravity  input  16  g, cm/s², unsigned
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when the last sample is accepted
- sample_valid  output  1  sample present
- sample_ready  input  1  consumer accepts
- sample_x  output  16  horizontal position, cm, saturated
- sample_y  output  16  height, cm, saturated
- sample_idx  output  IDX_W  sample number, 0-based
- sample_last  output  1  final sample of flight

## Operation
- FSM: IDLE, EMIT, STEP.
- IDLE: start=1 latches vx, g; x_acc=0, y_acc=0, vy_acc=vy<<DT_SHIFT, idx=0 → EMIT. Inputs are sampled only at start; later changes are ignored.
- EMIT: sample_valid=1; outputs are registers, stable while valid && !ready. On valid && ready: if sample_last → IDLE with done=1; else → STEP.
- STEP (one cycle, all from old values): x_acc += vx; y_acc += vy_acc; vy_acc -= g; idx += 1. → EMIT.
- Fixed point: x_acc has DT_SHIFT fraction bits, vy_acc DT_SHIFT, y_acc 2·DT_SHIFT. x_acc, y_acc, vy_acc are 40-bit signed.
- Output mapping: sample_x = x_acc>>DT_SHIFT, sample_y = y_acc>>(2·DT_SHIFT), each clamped to 0xFFFF. Negative y_acc → sample_y=0.
- sample_last is set when either holds:
  - after a STEP, y_acc<0 (touchdown). That sample reports y=0, with x at its stepped value.
  - idx == MAX_SAMPLES-1.
- Sample 0 is always (0,0), last=0. With vy=0 and g>0, touchdown occurs at idx 2.
- g=0: flight ends only by MAX_SAMPLES.
- start while busy: ignored.
- abort, any state: → IDLE next cycle; valid drops; done is not pulsed; abort has priority over handshake and start.
- Reset: state=IDLE; busy=0, done=0, sample_valid=0, sample_x=0, sample_y=0, sample_idx=0, sample_last=0; accumulators cleared.

## Timing
- start at edge N → busy=1 and sample 0 valid after edge N+1.
- Accept at edge M (not last) → STEP during M+1 → next sample valid after edge M+2. Peak throughput is 1 sample per 2 cycles.
- Last sample accepted at edge M → after M+1: done=1 for one cycle, busy=0, valid=0. A start is accepted on the cycle done is high.
- Outputs are registered; there is no combinational path from sample_ready to sample_valid or the data outputs.

## Structure
- Shared package contains:
  - state enum {IDLE, EMIT, STEP}
  - ACC_W=40
  - SAT16 max constant
  - unit-scale constants matching the upstream stage (×100)
- One sub-module, traj_step_datapath: holds the accumulators, the update equations, the saturation/clamp logic and the touchdown compare. The FSM and handshake logic stay in the top level.

## Test plan
1. DT_SHIFT=4, vx=100, vy=0, g=981, ready=1 → samples (0,0,idx0), (6,0,idx1), (12,0,idx2,last); done pulses once.
2. vx=0, vy=1600, g=0, MAX_SAMPLES=8 → y=0,100,…,700 for idx 0..7; last on idx7.
3. Backpressure: test 1 with ready toggling randomly → x, y and idx are held stable while stalled; same sequence delivered, no drops or duplicates.
4. vx=2000, vy=1000, g=981 → every sample matches a bit-exact reference model; touchdown sample has y=0 and last=1.
5. abort during STEP, then start on the next cycle → valid drops, no done pulse; the new flight begins at idx0 with (0,0).
6. Reset asserted mid-flight while valid && !ready → all outputs 0 immediately; start is ignored while busy; vx=0xFFFF with g=0 drives sample_x to saturate at 0xFFFF.

Source files
------------

// File: rtl/trajectory_sampler_pkg.sv
// trajectory_sampler_pkg
// Shared definitions for the trajectory sampler.
// Contents:
//   state_e    - sampler FSM states
//   ACC_W      - width of the signed fixed-point accumulators
//   SAT16_MAX  - clamp value for 16-bit position outputs
//   *_SCALE    - x100 unit scale used by the upstream parameter stage
//   sat_u16    - shift an accumulator down to integer cm and clamp to 0..0xFFFF
package trajectory_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        STEP = 2'd2
    } state_e;

    localparam int          ACC_W      = 40;
    localparam logic [15:0] SAT16_MAX  = 16'hFFFF;
    localparam int          VEL_SCALE  = 32'd100;
    localparam int          GRAV_SCALE = 32'd100;
    localparam int          POS_SCALE  = 32'd100;

    // Negative values (below ground) map to 0; anything above 16 bits clamps.
    function automatic logic [15:0] sat_u16(input logic signed [ACC_W-1:0] acc,
                                            input int                      shift);
        logic signed [ACC_W-1:0] scaled;
        scaled = acc >>> shift;
        if (acc[ACC_W-1]) begin
            sat_u16 = 16'd0;
        end else if (scaled[ACC_W-1:16] != {(ACC_W-16){1'b0}}) begin
            sat_u16 = SAT16_MAX;
        end else begin
            sat_u16 = scaled[15:0];
        end
    endfunction

endpackage

// File: rtl/trajectory_sampler_step.sv
// traj_step_datapath
// Fixed-point flight integrator. Holds the position/velocity accumulators,
// applies one Euler step per step_i, and keeps registered, clamped copies of
// the current position for the sampler outputs.
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   load_i               - start a flight: clear positions, latch vx/vy/g
//   step_i               - advance the flight by one time step
//   vx_i, vy_i, g_i      - launch velocity components and gravity (x100)
//   sample_x_o/_y_o      - registered clamped position in cm
//   touchdown_o          - the step taken this cycle ends below ground
module traj_step_datapath
    import trajectory_sampler_pkg::*;
#(
    parameter int DT_SHIFT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [15:0] vx_i,
    input  logic [15:0] vy_i,
    input  logic [15:0] g_i,
    output logic [15:0] sample_x_o,
    output logic [15:0] sample_y_o,
    output logic        touchdown_o
);

    localparam int EXT_W = ACC_W - 16;

    // x: DT_SHIFT fraction bits, vy: DT_SHIFT, y: 2*DT_SHIFT
    logic signed [ACC_W-1:0] x_acc_q, x_acc_d;
    logic signed [ACC_W-1:0] y_acc_q, y_acc_d;
    logic signed [ACC_W-1:0] vy_acc_q, vy_acc_d;
    logic [15:0]             vx_q, vx_d, g_q, g_d;
    logic [15:0]             sx_q, sx_d, sy_q, sy_d;

    // Next-state of the integrator; every update uses the old values only.
    always_comb begin
        x_acc_d  = x_acc_q;
        y_acc_d  = y_acc_q;
        vy_acc_d = vy_acc_q;
        vx_d     = vx_q;
        g_d      = g_q;
        if (load_i) begin
            x_acc_d  = {ACC_W{1'b0}};
            y_acc_d  = {ACC_W{1'b0}};
            vy_acc_d = {{EXT_W{1'b0}}, vy_i} << DT_SHIFT;
            vx_d     = vx_i;
            g_d      = g_i;
        end else if (step_i) begin
            x_acc_d  = x_acc_q + {{EXT_W{1'b0}}, vx_q};
            y_acc_d  = y_acc_q + vy_acc_q;
            vy_acc_d = vy_acc_q - {{EXT_W{1'b0}}, g_q};
        end else begin
            x_acc_d  = x_acc_q;
        end
        sx_d        = sat_u16(x_acc_d, DT_SHIFT);
        sy_d        = sat_u16(y_acc_d, 2 * DT_SHIFT);
        touchdown_o = step_i & y_acc_d[ACC_W-1];
    end

    // Accumulator and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_acc_q  <= {ACC_W{1'b0}};
            y_acc_q  <= {ACC_W{1'b0}};
            vy_acc_q <= {ACC_W{1'b0}};
            vx_q     <= 16'd0;
            g_q      <= 16'd0;
            sx_q     <= 16'd0;
            sy_q     <= 16'd0;
        end else begin
            x_acc_q  <= x_acc_d;
            y_acc_q  <= y_acc_d;
            vy_acc_q <= vy_acc_d;
            vx_q     <= vx_d;
            g_q      <= g_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
        end
    end

    assign sample_x_o = sx_q;
    assign sample_y_o = sy_q;

endmodule

// File: rtl/trajectory_sampler.sv
// trajectory_sampler
// Integrates a projectile flight in 2^-DT_SHIFT s steps and streams (x, y)
// samples over valid/ready until touchdown or MAX_SAMPLES samples.
// Ports:
//   clk, reset (async active-low), start, abort (synchronous)
//   horizontalVelocity, verticalVelocity, customGravity - launch inputs (x100)
//   busy, done                      - status; done pulses after the last accept
//   sample_valid/ready              - output handshake
//   sample_x, sample_y, sample_idx, sample_last - registered sample payload
module trajectory_sampler
    import trajectory_sampler_pkg::*;
#(
    parameter int DT_SHIFT    = 4,
    parameter int MAX_SAMPLES = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      horizontalVelocity,
    input  logic [15:0]      verticalVelocity,
    input  logic [15:0]      customGravity,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [15:0]      sample_x,
    output logic [15:0]      sample_y,
    output logic [IDX_W-1:0] sample_idx,
    output logic             sample_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SAMPLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             load_s, step_s, touchdown_s;

    // FSM next state, datapath controls and registered status next values.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_d = EMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (valid_q && sample_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = STEP;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            STEP: begin
                step_s  = 1'b1;
                state_d = EMIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort outranks start and the handshake, and suppresses done.
        if (abort) begin
            state_d = IDLE;
            load_s  = 1'b0;
            step_s  = 1'b0;
            done_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
        valid_d = (state_d == EMIT);
        busy_d  = (state_d != IDLE);
    end

    // Sample index and last flag; kept apart from the FSM block because
    // touchdown_s is derived from step_s through the datapath.
    always_comb begin
        idx_d  = idx_q;
        last_d = last_q;
        if (load_s) begin
            idx_d  = {IDX_W{1'b0}};
            last_d = 1'b0;
        end else if (step_s) begin
            idx_d  = idx_q + IDX_ONE;
            last_d = touchdown_s || ((idx_q + IDX_ONE) == LAST_IDX);
        end else begin
            idx_d  = idx_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    traj_step_datapath #(
        .DT_SHIFT (DT_SHIFT)
    ) u_datapath (
        .clk_i       (clk),
        .rst_ni      (reset),
        .load_i      (load_s),
        .step_i      (step_s),
        .vx_i        (horizontalVelocity),
        .vy_i        (verticalVelocity),
        .g_i         (customGravity),
        .sample_x_o  (sample_x),
        .sample_y_o  (sample_y),
        .touchdown_o (touchdown_s)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_valid = valid_q;
    assign sample_idx   = idx_q;
    assign sample_last  = last_q;

endmodule

// File: tb/tb_trajectory_sampler.sv
// tb_trajectory_sampler
// Directed bench for trajectory_sampler. Two instances share the inputs:
// dut_a uses MAX_SAMPLES=1024, dut_b uses MAX_SAMPLES=8; sel picks which
// instance's outputs the scenarios observe.
module tb_trajectory_sampler;

    logic        clk = 1'b0;
    logic        reset, start, abort, sample_ready;
    logic [15:0] vx, vy, g;

    logic        a_busy, a_done, a_valid, a_last;
    logic [15:0] a_x, a_y;
    logic [9:0]  a_idx;
    logic        b_busy, b_done, b_valid, b_last;
    logic [15:0] b_x, b_y;
    logic [9:0]  b_idx;

    logic        sel;
    logic        o_busy, o_done, o_valid, o_last;
    logic [15:0] o_x, o_y;
    logic [9:0]  o_idx;

    int checks   = 0;
    int failures = 0;

    int q_x[$];
    int q_y[$];
    int q_idx[$];
    bit q_last[$];

    always #5 clk = ~clk;

    trajectory_sampler #(.DT_SHIFT(4), .MAX_SAMPLES(1024), .IDX_W(10)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .horizontalVelocity(vx), .verticalVelocity(vy), .customGravity(g),
        .busy(a_busy), .done(a_done), .sample_valid(a_valid), .sample_ready(sample_ready),
        .sample_x(a_x), .sample_y(a_y), .sample_idx(a_idx), .sample_last(a_last));

    trajectory_sampler #(.DT_SHIFT(4), .MAX_SAMPLES(8), .IDX_W(10)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .horizontalVelocity(vx), .verticalVelocity(vy), .customGravity(g),
        .busy(b_busy), .done(b_done), .sample_valid(b_valid), .sample_ready(sample_ready),
        .sample_x(b_x), .sample_y(b_y), .sample_idx(b_idx), .sample_last(b_last));

    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_last  = sel ? b_last  : a_last;
    assign o_x     = sel ? b_x     : a_x;
    assign o_y     = sel ? b_y     : a_y;
    assign o_idx   = sel ? b_idx   : a_idx;

    task automatic pulse_start(input logic [15:0] x, input logic [15:0] y, input logic [15:0] gg);
        @(negedge clk);
        vx = x; vy = y; g = gg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_test();
        @(negedge clk);
        abort = 1'b1; start = 1'b0; sample_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Drives ready and records accepted samples; reports stall violations,
    // done pulses and whether the cycle budget ran out.
    task automatic collect(input int max_n, input bit rnd, output int stall_errs,
                           output int done_cnt, output bit timeout);
        logic [15:0] hx, hy;
        logic [9:0]  hi;
        logic        hl;
        bit          stalled, fin, rdy;
        q_x.delete(); q_y.delete(); q_idx.delete(); q_last.delete();
        stall_errs = 0; done_cnt = 0; timeout = 1'b1; stalled = 1'b0;
        hx = 16'd0; hy = 16'd0; hi = 10'd0; hl = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (o_done) done_cnt++;
            if (stalled && (!o_valid || o_x !== hx || o_y !== hy || o_idx !== hi || o_last !== hl))
                stall_errs++;
            rdy = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            sample_ready = rdy;
            stalled = o_valid && !rdy;
            hx = o_x; hy = o_y; hi = o_idx; hl = o_last;
            fin = 1'b0;
            if (o_valid && rdy) begin
                q_x.push_back(int'(o_x)); q_y.push_back(int'(o_y));
                q_idx.push_back(int'(o_idx)); q_last.push_back(o_last);
                if (o_last || q_x.size() == max_n) fin = 1'b1;
            end
            @(negedge clk);
            if (fin) begin
                if (q_last[q_last.size()-1]) begin
                    if (o_done) done_cnt++;
                    @(negedge clk);
                    if (o_done) done_cnt++;
                end
                timeout = 1'b0;
                break;
            end
        end
        sample_ready = 1'b1;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({o_busy, o_done, o_valid, o_last} !== 4'b0000 || o_x !== 16'd0 ||
                o_y !== 16'd0 || o_idx !== 10'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b valid=%b last=%b x=%0d y=%0d idx=%0d, expected all 0",
                         s, o_busy, o_done, o_valid, o_last, o_x, o_y, o_idx);
            end
        end
    endtask

    task automatic test_touchdown(input bit rnd, input string name);
        int exp_x[3] = '{0, 6, 12};
        int se, dc; bit to;
        begin_test();
        sel = 1'b0;
        pulse_start(16'd100, 16'd0, 16'd981);
        collect(16, rnd, se, dc, to);
        checks++;
        if (to !== 1'b0 || q_x.size() !== 3) begin
            failures++;
            $display("FAIL %s_count: got %0d samples timeout=%0d, expected 3 timeout=0", name, q_x.size(), to);
        end
        for (int i = 0; i < 3 && i < q_x.size(); i++) begin
            checks++;
            if (q_x[i] !== exp_x[i] || q_y[i] !== 0 || q_idx[i] !== i || q_last[i] !== (i == 2)) begin
                failures++;
                $display("FAIL %s_sample%0d: got x=%0d y=%0d idx=%0d last=%0d, expected x=%0d y=0 idx=%0d last=%0d",
                         name, i, q_x[i], q_y[i], q_idx[i], q_last[i], exp_x[i], i, (i == 2));
            end
        end
        checks++;
        if (dc !== 1 || se !== 0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: got done_pulses=%0d stall_errs=%0d busy=%b valid=%b, expected 1 0 0 0",
                     name, dc, se, o_busy, o_valid);
        end
    endtask

    task automatic test_max_samples();
        int se, dc; bit to;
        begin_test();
        sel = 1'b1;
        pulse_start(16'd0, 16'd1600, 16'd0);
        collect(16, 1'b0, se, dc, to);
        checks++;
        if (to !== 1'b0 || q_x.size() !== 8 || dc !== 1) begin
            failures++;
            $display("FAIL max_count: got %0d samples done=%0d timeout=%0d, expected 8 1 0", q_x.size(), dc, to);
        end
        for (int i = 0; i < 8 && i < q_x.size(); i++) begin
            checks++;
            if (q_x[i] !== 0 || q_y[i] !== 100 * i || q_idx[i] !== i || q_last[i] !== (i == 7)) begin
                failures++;
                $display("FAIL max_sample%0d: got x=%0d y=%0d idx=%0d last=%0d, expected x=0 y=%0d idx=%0d last=%0d",
                         i, q_x[i], q_y[i], q_idx[i], q_last[i], 100 * i, i, (i == 7));
            end
        end
    endtask

    task automatic test_reference();
        longint mx, my, mv;
        int ex[$]; int ey[$]; bit el[$];
        int se, dc; bit to; bit lst;
        mx = 0; my = 0; mv = 64'sd1000 * 16;
        for (int k = 0; k < 1024; k++) begin
            ex.push_back((mx >>> 4) > 65535 ? 65535 : int'(mx >>> 4));
            ey.push_back(my < 0 ? 0 : ((my >>> 8) > 65535 ? 65535 : int'(my >>> 8)));
            lst = (k > 0 && my < 0) || (k == 1023);
            el.push_back(lst);
            if (lst) break;
            mx = mx + 2000; my = my + mv; mv = mv - 981;
        end
        begin_test();
        sel = 1'b0;
        pulse_start(16'd2000, 16'd1000, 16'd981);
        collect(2000, 1'b0, se, dc, to);
        checks++;
        if (to !== 1'b0 || q_x.size() !== 35 || ex.size() !== 35) begin
            failures++;
            $display("FAIL ref_count: got %0d samples (model %0d) timeout=%0d, expected 35",
                     q_x.size(), ex.size(), to);
        end
        for (int i = 0; i < ex.size() && i < q_x.size(); i++) begin
            checks++;
            if (q_x[i] !== ex[i] || q_y[i] !== ey[i] || q_idx[i] !== i || q_last[i] !== el[i]) begin
                failures++;
                $display("FAIL ref_sample%0d: got x=%0d y=%0d idx=%0d last=%0d, expected x=%0d y=%0d idx=%0d last=%0d",
                         i, q_x[i], q_y[i], q_idx[i], q_last[i], ex[i], ey[i], i, el[i]);
            end
        end
        checks++;
        if (q_x.size() == 0 || q_y[q_y.size()-1] !== 0 || q_last[q_last.size()-1] !== 1'b1 || dc !== 1) begin
            failures++;
            $display("FAIL ref_touchdown: got %0d samples, final y/last/done not 0/1/1 (done=%0d)", q_x.size(), dc);
        end
    endtask

    task automatic test_abort();
        int se, dc; bit to;
        begin_test();
        sel = 1'b0;
        pulse_start(16'd100, 16'd0, 16'd981);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_step: got busy=%b valid=%b, expected 1 0", o_busy, o_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b valid=%b done=%b, expected 0 0 0", o_busy, o_valid, o_done);
        end
        vx = 16'd100; vy = 16'd0; g = 16'd981; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_idx !== 10'd0 || o_x !== 16'd0 || o_y !== 16'd0 || o_last !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart: got valid=%b idx=%0d x=%0d y=%0d last=%b, expected 1 0 0 0 0",
                     o_valid, o_idx, o_x, o_y, o_last);
        end
        collect(16, 1'b0, se, dc, to);
        checks++;
        if (to !== 1'b0 || q_x.size() !== 3 || dc !== 1 || q_x[q_x.size()-1] !== 12) begin
            failures++;
            $display("FAIL abort_flight: got %0d samples done=%0d timeout=%0d, expected 3 samples ending x=12, done=1",
                     q_x.size(), dc, to);
        end
    endtask

    task automatic test_reset_mid_flight();
        int se, dc; bit to; int ex;
        begin_test();
        sel = 1'b0;
        sample_ready = 1'b0;
        pulse_start(16'd100, 16'd1600, 16'd0);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_x !== 16'd6 || o_y !== 16'd100 || o_idx !== 10'd1) begin
            failures++;
            $display("FAIL stalled_sample: got valid=%b x=%0d y=%0d idx=%0d, expected 1 6 100 1",
                     o_valid, o_x, o_y, o_idx);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_valid, o_last} !== 4'b0000 || o_x !== 16'd0 ||
            o_y !== 16'd0 || o_idx !== 10'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b valid=%b last=%b x=%0d y=%0d idx=%0d, expected all 0",
                     o_busy, o_done, o_valid, o_last, o_x, o_y, o_idx);
        end
        @(negedge clk);
        reset = 1'b1;
        // Saturating flight; a second start while busy must be ignored.
        pulse_start(16'hFFFF, 16'd0, 16'd0);
        pulse_start(16'h0001, 16'd5000, 16'd5);
        collect(20, 1'b0, se, dc, to);
        checks++;
        if (to !== 1'b0 || q_x.size() !== 20 || dc !== 0) begin
            failures++;
            $display("FAIL sat_count: got %0d samples done=%0d timeout=%0d, expected 20 0 0", q_x.size(), dc, to);
        end
        for (int k = 0; k < q_x.size(); k++) begin
            ex = ((65535 * k) >> 4) > 65535 ? 65535 : ((65535 * k) >> 4);
            checks++;
            if (q_x[k] !== ex || q_y[k] !== 0 || q_idx[k] !== k || q_last[k] !== 1'b0) begin
                failures++;
                $display("FAIL sat_sample%0d: got x=%0d y=%0d idx=%0d last=%0d, expected x=%0d y=0 idx=%0d last=0",
                         k, q_x[k], q_y[k], q_idx[k], q_last[k], ex, k);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; sample_ready = 1'b1;
        vx = 16'd0; vy = 16'd0; g = 16'd0; sel = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_touchdown(1'b0, "touchdown");
        test_max_samples();
        test_touchdown(1'b1, "backpressure");
        test_reference();
        test_abort();
        test_reset_mid_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
